// File: rtl/spi_slave_mode_if.sv
// SPI slave bus bundle: serial pins, parallel tx/rx handshake and sticky status flags.
interface spi_slave_mode_if #(
  parameter int DATA_W = 8
);
  logic              sclk;
  logic              cs;
  logic              mosi;
  logic              miso;
  logic [DATA_W-1:0] tx_data;
  logic              tx_load;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ack;
  logic              busy;
  logic              overrun;
  logic              underrun;

  modport slave (
    input  sclk, cs, mosi, tx_data, tx_load, rx_ack,
    output miso, tx_ready, rx_data, rx_valid, busy, overrun, underrun
  );

  modport master (
    output sclk, cs, mosi, tx_data, tx_load, rx_ack,
    input  miso, tx_ready, rx_data, rx_valid, busy, overrun, underrun
  );
endinterface

// File: rtl/spi_slave_mode.sv
// SPI slave clocked entirely by clk: oversamples sclk/cs/mosi, single-word tx buffer,
// rx holding register with valid/ack handshake, sticky overrun/underrun flags.
module spi_slave_mode #(
  parameter int DATA_W    = 8,
  parameter int CPOL      = 0,
  parameter int CPHA      = 0,
  parameter int MSB_FIRST = 1
) (
  input logic             clk,
  input logic             rst,
  spi_slave_mode_if.slave bus
);
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;

  localparam int               CNT_W     = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_W - 1);
  localparam logic             SCLK_IDLE = (CPOL != 0);
  localparam logic             CPHA_ON   = (CPHA != 0);
  localparam logic             MSB_ON    = (MSB_FIRST != 0);

  logic              sclk_p0, sclk_p1, sclk_p2;
  logic              cs_p0, cs_p1;
  logic              mosi_p0, mosi_p1;

  logic [0:0]        state;
  logic              armed;
  logic              skip_shift;
  logic [CNT_W-1:0]  bit_cnt;

  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] tx_buf;
  logic              tx_full;
  logic [DATA_W-1:0] rx_shift;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              overrun;
  logic              underrun;

  logic              lead_edge, trail_edge;
  logic              sample_edge, shift_edge;
  logic              word_done, word_start;
  logic [DATA_W-1:0] rx_next;

  // Stage p0/p1: two-flop synchronizers; p2 keeps the previous sclk for edge detection.
  // cs clears low so a cs held low through reset never reads as a fresh high-to-low.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_p0 <= SCLK_IDLE;
      sclk_p1 <= SCLK_IDLE;
      sclk_p2 <= SCLK_IDLE;
      cs_p0   <= 1'b0;
      cs_p1   <= 1'b0;
      mosi_p0 <= 1'b0;
      mosi_p1 <= 1'b0;
    end else begin
      sclk_p0 <= bus.sclk;
      sclk_p1 <= sclk_p0;
      sclk_p2 <= sclk_p1;
      cs_p0   <= bus.cs;
      cs_p1   <= cs_p0;
      mosi_p0 <= bus.mosi;
      mosi_p1 <= mosi_p0;
    end
  end

  always_comb begin
    lead_edge   = (sclk_p1 != SCLK_IDLE) && (sclk_p2 == SCLK_IDLE);
    trail_edge  = (sclk_p1 == SCLK_IDLE) && (sclk_p2 != SCLK_IDLE);
    sample_edge = (state == ACTIVE) && !cs_p1 && (CPHA_ON ? trail_edge : lead_edge);
    shift_edge  = (state == ACTIVE) && !cs_p1 && (CPHA_ON ? lead_edge : trail_edge);
    word_done   = sample_edge && (bit_cnt == LAST_BIT);
    word_start  = ((state == IDLE) && !cs_p1 && armed) || word_done;
    rx_next     = MSB_ON ? {rx_shift[DATA_W-2:0], mosi_p1}
                         : {mosi_p1, rx_shift[DATA_W-1:1]};
  end

  // The first shift edge after a word start is swallowed: with CPHA=1 it is the edge that
  // presents bit 0, with CPHA=0 it is the trailing edge of the word that just finished.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      armed      <= 1'b0;
      skip_shift <= 1'b0;
      bit_cnt    <= '0;
    end else begin
      if (cs_p1) armed <= 1'b1;
      if (state == IDLE) begin
        if (word_start) begin
          state      <= ACTIVE;
          bit_cnt    <= '0;
          skip_shift <= CPHA_ON;
        end
      end else if (cs_p1) begin
        state      <= IDLE;
        bit_cnt    <= '0;
        skip_shift <= 1'b0;
      end else begin
        if (sample_edge) bit_cnt <= word_done ? '0 : bit_cnt + CNT_W'(1);
        if (word_done) skip_shift <= 1'b1;
        else if (shift_edge) skip_shift <= 1'b0;
      end
    end
  end

  // A load accepted in the same clk as a word start refills the buffer for the next word.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_shift <= '0;
      tx_buf   <= '0;
      tx_full  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      if (word_start) begin
        tx_shift <= tx_full ? tx_buf : '0;
        tx_full  <= 1'b0;
        if (!tx_full) underrun <= 1'b1;
      end else if (shift_edge && !skip_shift) begin
        tx_shift <= MSB_ON ? (tx_shift << 1) : (tx_shift >> 1);
      end
      if (bus.tx_load && !tx_full) begin
        tx_buf  <= bus.tx_data;
        tx_full <= 1'b1;
      end
    end
  end

  // An ack landing with a completion keeps rx_valid set for the new word and is not an overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_shift <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (bus.rx_ack) rx_valid <= 1'b0;
      if ((state == ACTIVE) && cs_p1) begin
        rx_shift <= '0;
      end else if (sample_edge) begin
        rx_shift <= rx_next;
        if (word_done) begin
          rx_data  <= rx_next;
          rx_valid <= 1'b1;
          if (rx_valid && !bus.rx_ack) overrun <= 1'b1;
        end
      end
    end
  end

  assign bus.miso     = (state == ACTIVE) && (MSB_ON ? tx_shift[DATA_W-1] : tx_shift[0]);
  assign bus.tx_ready = !tx_full;
  assign bus.rx_data  = rx_data;
  assign bus.rx_valid = rx_valid;
  assign bus.busy     = (state == ACTIVE);
  assign bus.overrun  = overrun;
  assign bus.underrun = underrun;
endmodule

// File: doc/spi_slave_mode.md
SPI_SLAVE_MODE -- requirements
Module: spi_slave_mode

Interface
REQ-001 Parameter DATA_W, default 8, word length in bits (range 4..32).
REQ-002 Parameter CPOL, default 0, SCLK idle level.
REQ-003 Parameter CPHA, default 0, selects the sample edge: 0 = leading, 1 = trailing.
REQ-004 Parameter MSB_FIRST, default 1; 1 = MSB shifted first, 0 = LSB first.
REQ-005 clk  input  1  system clock; all logic SHALL be rising-edge clk only.
REQ-006 rst  input  1  reset; synchronous, active-high.
REQ-007 sclk  input  1  SPI clock, asynchronous to clk.
REQ-008 cs  input  1  chip select, active-low, asynchronous.
REQ-009 mosi  input  1  serial data in, asynchronous.
REQ-010 miso  output  1  serial data out.
REQ-011 tx_data  input  DATA_W  word to transmit.
REQ-012 tx_load  input  1  writes tx_data into the tx buffer when tx_ready=1.
REQ-013 tx_ready  output  1  high when the tx buffer is empty.
REQ-014 rx_data  output  DATA_W  last complete received word.
REQ-015 rx_valid  output  1  high while rx_data is unread.
REQ-016 rx_ack  input  1  clears rx_valid.
REQ-017 busy  output  1  high in state ACTIVE.
REQ-018 overrun  output  1  sticky: a word completed while rx_valid=1.
REQ-019 underrun  output  1  sticky: a word started with the tx buffer empty.

Function
REQ-020 sclk, cs and mosi SHALL each pass through a 2-flop synchronizer; edges SHALL be detected on the synchronized sclk. Requirement: f_clk >= 4 x f_sclk.
REQ-021 Leading edge = sclk transition away from CPOL; trailing edge = transition back to CPOL.
REQ-022 Shift edge = trailing edge if CPHA=0, leading edge if CPHA=1. Sample edge = the other edge.
REQ-023 FSM states: IDLE and ACTIVE. IDLE->ACTIVE on synchronized cs=0. ACTIVE->IDLE on synchronized cs=1.
REQ-024 Word start: on IDLE->ACTIVE, and on each word completion while cs stays 0. At word start: tx shift register <= tx buffer and buffer marked empty; bit counter <= 0.
REQ-025 Word start with an empty tx buffer: shift register <= 0 and underrun <= 1.
REQ-026 miso presents the current first-order bit of the shift register. With CPHA=0 the first bit is valid from word start. On each shift edge the register advances one bit in MSB_FIRST order.
REQ-027 Sample edge: the synchronized mosi enters the rx shift register in MSB_FIRST order and the bit counter increments.
REQ-028 At the DATA_W-th sample: rx_data <= assembled word, and rx_valid = 1 on the next clk. If rx_valid was already 1, rx_data is overwritten and overrun <= 1.
REQ-029 Latency: final sample sclk pin edge -> rx_valid high <= 4 clk.
REQ-030 Sample completion and rx_ack in the same clk: rx_valid stays 1 (new word); overrun is not set.
REQ-031 cs deasserted mid-word: partial word discarded, no rx_valid, bit counter <= 0. An unconsumed tx buffer is retained.
REQ-032 tx_load with tx_ready=0 is ignored. tx_load in the same clk as word start loads the buffer for the next word.
REQ-033 miso SHALL be 0 in IDLE; no tri-state.
REQ-034 Bit counter wraps from DATA_W-1 to 0; no other count value is reachable.
REQ-035 busy is high in ACTIVE and low in IDLE.

Reset
REQ-036 rst=1 at a rising clk: state=IDLE, counters=0, shift registers=0, rx_data=0, rx_valid=0, tx_ready=1, miso=0, busy=0, overrun=0, underrun=0.
REQ-037 rst mid-word aborts the transfer. Operation resumes only after cs is observed high then low.
REQ-038 overrun and underrun are cleared only by rst.

Verification
REQ-039 DATA_W=8, mode 0, MSB first, tx 0xA5 loaded, master sends 0x3C -> master receives 0xA5; rx_data=0x3C; rx_valid within 4 clk of the 8th rising sclk.
REQ-040 Mode 3 (CPOL=1, CPHA=1), LSB first, DATA_W=16, master sends 0x1234 -> rx_data=0x1234; miso changes only on falling sclk.
REQ-041 Two back-to-back words 0x11, 0x22 with cs held low, no rx_ack -> rx_data=0x22, overrun=1, rx_valid=1.
REQ-042 cs raised after 5 bits, then full word 0x81 -> only one rx_valid; rx_data=0x81.
REQ-043 No tx_load before transfer -> master receives 0x00; underrun=1; tx_ready stays 1.
REQ-044 rst asserted at bit 3 with cs held low -> all outputs at reset values; no rx_valid until cs toggles high then low.
